// File: rtl/schedule_table_pkg.sv
// Shared NoC definitions: slot-table entry layout and index/address widths,
// common to the schedule table and the TDM controller.
package schedule_table_pkg;

  localparam int STBL_ENTRY_W = 32;
  localparam int STBL_IDX_W   = 8;
  localparam int CFG_ADDR_W   = 14;

  // Entry field bit ranges
  localparam int ROUTE_MSB     = 31;
  localparam int ROUTE_LSB     = 16;
  localparam int T2N_MSB       = 15;
  localparam int T2N_LSB       = 12;
  localparam int PKT_LEN_MSB   = 11;
  localparam int PKT_LEN_LSB   = 9;
  localparam int DMA_VALID_BIT = 8;
  localparam int DMA_NUM_MSB   = 7;
  localparam int DMA_NUM_LSB   = 0;

  localparam int ROUTE_W   = ROUTE_MSB - ROUTE_LSB + 1;
  localparam int T2N_W     = T2N_MSB - T2N_LSB + 1;
  localparam int PKT_LEN_W = PKT_LEN_MSB - PKT_LEN_LSB + 1;
  localparam int DMA_NUM_W = DMA_NUM_MSB - DMA_NUM_LSB + 1;

endpackage

// File: rtl/schedule_table_if.sv
// Configuration bus between the config master and the schedule table.
interface schedule_table_if;
  import schedule_table_pkg::*;

  logic                    sel;
  logic                    config_en;
  logic                    config_wr;
  logic [CFG_ADDR_W-1:0]   config_addr;
  logic [STBL_ENTRY_W-1:0] config_wdata;
  logic [STBL_ENTRY_W-1:0] config_slv_rdata;
  logic                    config_slv_error;

  modport master (
    output sel, config_en, config_wr, config_addr, config_wdata,
    input  config_slv_rdata, config_slv_error
  );

  modport slave (
    input  sel, config_en, config_wr, config_addr, config_wdata,
    output config_slv_rdata, config_slv_error
  );

endinterface

// File: rtl/schedule_table_stbl_ram.sv
// Slot-table storage: port A is a read-only schedule port, port B is the
// config read/write port. Both reads are synchronous and read-before-write.
module stbl_ram
  import schedule_table_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                    clk,
  input  logic [AW-1:0]           i_a_addr,
  output logic [STBL_ENTRY_W-1:0] o_a_rdata,
  input  logic [AW-1:0]           i_b_addr,
  input  logic                    i_b_we,
  input  logic [STBL_ENTRY_W-1:0] i_b_wdata,
  output logic [STBL_ENTRY_W-1:0] o_b_rdata
);

  logic [STBL_ENTRY_W-1:0] r_mem [DEPTH];

  // Schedule read port
  always_ff @(posedge clk) begin
    o_a_rdata <= r_mem[i_a_addr];
  end

  // Config read/write port, old data returned on a write
  always_ff @(posedge clk) begin
    if (i_b_we) begin
      r_mem[i_b_addr] <= i_b_wdata;
    end
    o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/schedule_table.sv
// TDM slot schedule table: maps a slot index to route/slot-length/DMA fields,
// pulses dma_en for slots that carry a DMA packet while the network runs,
// and exposes the table over a registered config bus.
module schedule_table
  import schedule_table_pkg::*;
#(
  parameter int STBL_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [STBL_IDX_W-1:0] stbl_idx,
  input  logic                  stbl_idx_en,
  schedule_table_if.slave       cfg,
  output logic [T2N_W-1:0]      t2n,
  output logic [ROUTE_W-1:0]    route,
  output logic [PKT_LEN_W-1:0]  pkt_len,
  output logic [DMA_NUM_W-1:0]  dma_num,
  output logic                  dma_en
);

  localparam int AW = $clog2(STBL_DEPTH);

  logic                    w_cfg_hit;
  logic                    w_cfg_ok;
  logic                    w_cfg_we;
  logic [STBL_ENTRY_W-1:0] w_a_rdata;
  logic [STBL_ENTRY_W-1:0] w_b_rdata;
  logic [STBL_ENTRY_W-1:0] w_entry;

  logic                    r_sched_vld_p1;
  logic                    r_run_p1;
  logic                    r_cfg_rd_p1;
  logic                    r_cfg_err_p1;
  logic [STBL_ENTRY_W-1:0] r_entry_hold;

  // Upper address bits select other register banks; the index must be in range
  assign w_cfg_hit = cfg.sel & cfg.config_en;
  assign w_cfg_ok  = (cfg.config_addr[CFG_ADDR_W-1:STBL_IDX_W] == '0) &&
                     ({1'b0, cfg.config_addr[STBL_IDX_W-1:0]} < (STBL_IDX_W+1)'(STBL_DEPTH));
  assign w_cfg_we  = w_cfg_hit & cfg.config_wr & w_cfg_ok & ~reset;

  stbl_ram #(
    .DEPTH (STBL_DEPTH),
    .AW    (AW)
  ) u_stbl_ram (
    .clk       (clk),
    .i_a_addr  (stbl_idx[AW-1:0]),
    .o_a_rdata (w_a_rdata),
    .i_b_addr  (cfg.config_addr[AW-1:0]),
    .i_b_we    (w_cfg_we),
    .i_b_wdata (cfg.config_wdata),
    .o_b_rdata (w_b_rdata)
  );

  // p0 -> p1: request qualifiers follow the RAM read by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sched_vld_p1 <= 1'b0;
      r_run_p1       <= 1'b0;
      r_cfg_rd_p1    <= 1'b0;
      r_cfg_err_p1   <= 1'b0;
    end else begin
      r_sched_vld_p1 <= stbl_idx_en;
      r_run_p1       <= run;
      r_cfg_rd_p1    <= w_cfg_hit & ~cfg.config_wr & w_cfg_ok;
      r_cfg_err_p1   <= w_cfg_hit & ~w_cfg_ok;
    end
  end

  // Keep the current entry once the RAM port moves on to other addresses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry_hold <= '0;
    end else if (r_sched_vld_p1) begin
      r_entry_hold <= w_a_rdata;
    end
  end

  assign w_entry = r_sched_vld_p1 ? w_a_rdata : r_entry_hold;

  assign route   = w_entry[ROUTE_MSB:ROUTE_LSB];
  assign t2n     = w_entry[T2N_MSB:T2N_LSB];
  assign pkt_len = w_entry[PKT_LEN_MSB:PKT_LEN_LSB];
  assign dma_num = w_entry[DMA_NUM_MSB:DMA_NUM_LSB];
  assign dma_en  = r_sched_vld_p1 & r_run_p1 & w_a_rdata[DMA_VALID_BIT];

  assign cfg.config_slv_rdata = r_cfg_rd_p1 ? w_b_rdata : '0;
  assign cfg.config_slv_error = r_cfg_err_p1;

endmodule

// File: tb/tb_schedule_table.sv
// Directed bench for schedule_table: a default-depth instance and a
// 16-entry instance driven from one linear stimulus sequence.
module tb_schedule_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_a, run_b;
  logic [7:0]  idx_a, idx_b;
  logic        idx_en_a, idx_en_b;
  logic [3:0]  t2n_a, t2n_b;
  logic [15:0] route_a, route_b;
  logic [2:0]  pkt_len_a, pkt_len_b;
  logic [7:0]  dma_num_a, dma_num_b;
  logic        dma_en_a, dma_en_b;

  int checks = 0;
  int errors = 0;

  schedule_table_if cfg_a ();
  schedule_table_if cfg_b ();

  always #5 clk = ~clk;

  schedule_table dut_a (
    .clk         (clk),
    .reset       (reset),
    .run         (run_a),
    .stbl_idx    (idx_a),
    .stbl_idx_en (idx_en_a),
    .cfg         (cfg_a),
    .t2n         (t2n_a),
    .route       (route_a),
    .pkt_len     (pkt_len_a),
    .dma_num     (dma_num_a),
    .dma_en      (dma_en_a)
  );

  schedule_table #(.STBL_DEPTH(16)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .run         (run_b),
    .stbl_idx    (idx_b),
    .stbl_idx_en (idx_en_b),
    .cfg         (cfg_b),
    .t2n         (t2n_b),
    .route       (route_b),
    .pkt_len     (pkt_len_b),
    .dma_num     (dma_num_b),
    .dma_en      (dma_en_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a_drive(input logic s, input logic en, input logic wr,
                             input logic [13:0] addr, input logic [31:0] wd);
    cfg_a.sel = s; cfg_a.config_en = en; cfg_a.config_wr = wr;
    cfg_a.config_addr = addr; cfg_a.config_wdata = wd;
  endtask

  task automatic cfg_b_drive(input logic s, input logic en, input logic wr,
                             input logic [13:0] addr, input logic [31:0] wd);
    cfg_b.sel = s; cfg_b.config_en = en; cfg_b.config_wr = wr;
    cfg_b.config_addr = addr; cfg_b.config_wdata = wd;
  endtask

  task automatic sched_a(input logic en, input logic [7:0] idx, input logic r);
    idx_en_a = en; idx_a = idx; run_a = r;
  endtask

  task automatic check_a_fields(input string tag, input logic [15:0] rt, input logic [3:0] t,
                                input logic [2:0] pl, input logic [7:0] dn, input logic de);
    check({tag, "_route"},   32'(route_a),   32'(rt));
    check({tag, "_t2n"},     32'(t2n_a),     32'(t));
    check({tag, "_pkt_len"}, 32'(pkt_len_a), 32'(pl));
    check({tag, "_dma_num"}, 32'(dma_num_a), 32'(dn));
    check({tag, "_dma_en"},  32'(dma_en_a),  32'(de));
  endtask

  initial begin
    reset = 1'b1;
    sched_a(1'b0, 8'd0, 1'b0);
    run_b = 1'b0; idx_b = 8'd0; idx_en_b = 1'b0;
    cfg_a_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'd0);
    cfg_b_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'd0);

    // Reset state
    tick(); tick();
    check_a_fields("rst", 16'h0, 4'h0, 3'h0, 8'h0, 1'b0);
    check("rst_rdata", cfg_a.config_slv_rdata, 32'h0);
    check("rst_err",   32'(cfg_a.config_slv_error), 32'h0);
    check("rst_b_route", 32'(route_b), 32'h0);

    // Populate entries 5, 0 and 9
    reset = 1'b0;
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'd5, 32'h1234_3B07);
    tick();
    check("wr5_rdata", cfg_a.config_slv_rdata, 32'h0);
    check("wr5_err",   32'(cfg_a.config_slv_error), 32'h0);
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'd0, 32'h5555_2100);
    tick();
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'd9, 32'h0000_4105);
    tick();
    cfg_a_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);

    // Schedule entry 5 while running: one-cycle dma_en pulse
    sched_a(1'b1, 8'd5, 1'b1);
    tick();
    check_a_fields("s5_run", 16'h1234, 4'h3, 3'h5, 8'h07, 1'b1);
    sched_a(1'b0, 8'd0, 1'b1);
    tick();
    check("s5_hold_route", 32'(route_a), 32'h1234);
    check("s5_hold_dma_en", 32'(dma_en_a), 32'h0);

    // Not running: fields still update, no DMA issue
    sched_a(1'b1, 8'd0, 1'b0);
    tick();
    check_a_fields("s0_norun", 16'h5555, 4'h2, 3'h0, 8'h00, 1'b0);
    sched_a(1'b1, 8'd5, 1'b0);
    tick();
    check_a_fields("s5_norun", 16'h1234, 4'h3, 3'h5, 8'h07, 1'b0);
    sched_a(1'b0, 8'd0, 1'b0);

    // Config read-back
    cfg_a_drive(1'b1, 1'b1, 1'b0, 14'd5, 32'h0);
    tick();
    check("rd5_rdata", cfg_a.config_slv_rdata, 32'h1234_3B07);
    check("rd5_err",   32'(cfg_a.config_slv_error), 32'h0);

    // Out-of-range bank write
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'h0100, 32'hDEAD_BEEF);
    tick();
    check("bad_err",   32'(cfg_a.config_slv_error), 32'h1);
    check("bad_rdata", cfg_a.config_slv_rdata, 32'h0);
    cfg_a_drive(1'b1, 1'b1, 1'b0, 14'd0, 32'h0);
    tick();
    check("bad_err_clr", 32'(cfg_a.config_slv_error), 32'h0);
    check("rd0_unchanged", cfg_a.config_slv_rdata, 32'h5555_2100);

    // Not addressed: response is zero
    cfg_a_drive(1'b0, 1'b1, 1'b0, 14'd5, 32'h0);
    tick();
    check("noaddr_rdata", cfg_a.config_slv_rdata, 32'h0);
    check("noaddr_err",   32'(cfg_a.config_slv_error), 32'h0);

    // Same-cycle write and schedule read of entry 9: old value first
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'd9, 32'hAAAA_1000);
    sched_a(1'b1, 8'd9, 1'b1);
    tick();
    check_a_fields("rbw_old", 16'h0000, 4'h4, 3'h0, 8'h05, 1'b1);
    cfg_a_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
    tick();
    check_a_fields("rbw_new", 16'hAAAA, 4'h1, 3'h0, 8'h00, 1'b0);

    // Concurrent config read and schedule read
    cfg_a_drive(1'b1, 1'b1, 1'b0, 14'd5, 32'h0);
    sched_a(1'b1, 8'd0, 1'b1);
    tick();
    check("dual_rdata", cfg_a.config_slv_rdata, 32'h1234_3B07);
    check("dual_route", 32'(route_a), 32'h5555);

    // Reset mid-schedule with reads in flight
    reset = 1'b1;
    sched_a(1'b1, 8'd5, 1'b1);
    cfg_a_drive(1'b1, 1'b1, 1'b0, 14'd5, 32'h0);
    tick();
    check_a_fields("rstmid", 16'h0, 4'h0, 3'h0, 8'h0, 1'b0);
    check("rstmid_rdata", cfg_a.config_slv_rdata, 32'h0);
    cfg_a_drive(1'b1, 1'b1, 1'b1, 14'd5, 32'hFFFF_FFFF);
    sched_a(1'b0, 8'd0, 1'b0);
    tick();
    check("rstwr_rdata", cfg_a.config_slv_rdata, 32'h0);
    reset = 1'b0;
    cfg_a_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
    tick();
    check("post_rst_route",  32'(route_a), 32'h0);
    check("post_rst_dma_en", 32'(dma_en_a), 32'h0);
    check("post_rst_rdata",  cfg_a.config_slv_rdata, 32'h0);
    check("post_rst_err",    32'(cfg_a.config_slv_error), 32'h0);
    cfg_a_drive(1'b1, 1'b1, 1'b0, 14'd5, 32'h0);
    tick();
    check("post_rst_rd5", cfg_a.config_slv_rdata, 32'h1234_3B07);
    cfg_a_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);

    // 16-entry instance: index wrap and range check
    cfg_b_drive(1'b1, 1'b1, 1'b1, 14'd3, 32'h7777_2203);
    tick();
    cfg_b_drive(1'b1, 1'b1, 1'b1, 14'd4, 32'h0000_0004);
    tick();
    cfg_b_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
    idx_b = 8'h13; idx_en_b = 1'b1; run_b = 1'b1;
    tick();
    check("b_wrap_route",   32'(route_b),   32'h7777);
    check("b_wrap_t2n",     32'(t2n_b),     32'h2);
    check("b_wrap_pkt_len", 32'(pkt_len_b), 32'h1);
    check("b_wrap_dma_num", 32'(dma_num_b), 32'h03);
    check("b_wrap_dma_en",  32'(dma_en_b),  32'h0);
    idx_en_b = 1'b0;
    cfg_b_drive(1'b1, 1'b1, 1'b0, 14'd20, 32'h0);
    tick();
    check("b_rd20_err",   32'(cfg_b.config_slv_error), 32'h1);
    check("b_rd20_rdata", cfg_b.config_slv_rdata, 32'h0);
    cfg_b_drive(1'b1, 1'b1, 1'b1, 14'd20, 32'hFFFF_FFFF);
    tick();
    check("b_wr20_err", 32'(cfg_b.config_slv_error), 32'h1);
    cfg_b_drive(1'b1, 1'b1, 1'b0, 14'd4, 32'h0);
    tick();
    check("b_rd4_intact", cfg_b.config_slv_rdata, 32'h0000_0004);
    check("b_rd4_err",    32'(cfg_b.config_slv_error), 32'h0);
    cfg_b_drive(1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/schedule_table.md
SCHEDULE_TABLE -- requirements
Module: schedule_table

Interface
REQ-001 SHALL have parameter STBL_DEPTH, default 256, number of slot-table entries (power of two, max 256).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port run  in  1  network running; gates DMA issue.
REQ-005 SHALL have port stbl_idx  in  8  slot index from the TDM controller.
REQ-006 SHALL have port stbl_idx_en  in  1  stbl_idx valid this cycle (new slot).
REQ-007 SHALL have ports sel, config_en, config_wr  in  1 each  config bus select, access enable, write(1)/read(0).
REQ-008 SHALL have ports config_addr  in  14 and config_wdata  in  32  config word address and write data.
REQ-009 SHALL have ports config_slv_rdata  out  32 and config_slv_error  out  1  registered config response.
REQ-010 SHALL have port t2n  out  4  slot length of the current entry, fed back to the TDM controller.
REQ-011 SHALL have ports route  out  16, pkt_len  out  3, dma_num  out  8  fields of the current entry.
REQ-012 SHALL have port dma_en  out  1  one-cycle pulse: issue packet from DMA dma_num this slot.

Function
REQ-013 SHALL store STBL_DEPTH 32-bit entries: [31:16] route, [15:12] t2n, [11:9] pkt_len, [8] dma_valid, [7:0] dma_num.
REQ-014 SHALL, when stbl_idx_en=1 in cycle N, present entry[stbl_idx] on route/t2n/pkt_len/dma_num from cycle N+1 (1-cycle latency), held until the next stbl_idx_en.
REQ-015 SHALL assert dma_en in cycle N+1 only, iff dma_valid of the entry is 1 and run=1 in cycle N; otherwise dma_en=0.
REQ-016 SHALL treat an access as addressed when sel=1 and config_en=1; addressed entry index is config_addr[7:0].
REQ-017 SHALL, on an addressed write with config_addr[13:8]=0 and index<STBL_DEPTH, write config_wdata into the entry at cycle end.
REQ-018 SHALL, on an addressed read with a valid address, return the entry on config_slv_rdata in the following cycle.
REQ-019 SHALL, for an addressed access with config_addr[13:8]!=0 or index>=STBL_DEPTH, perform no write, return 0 data and pulse config_slv_error=1 in the following cycle.
REQ-020 SHALL hold config_slv_rdata=0 and config_slv_error=0 in any cycle following a non-addressed cycle.
REQ-021 SHALL, on a same-cycle config write and schedule read of the same index, return the old entry to the schedule path (read-before-write); the new value is visible from the next stbl_idx_en.
REQ-022 SHALL, on a same-cycle config read and schedule read, serve both (two read ports or one read + one read/write port).
REQ-023 SHALL ignore stbl_idx bits beyond log2(STBL_DEPTH) (index wraps modulo STBL_DEPTH).

Reset
REQ-024 SHALL, while reset=1, drive t2n, route, pkt_len, dma_num, dma_en, config_slv_rdata, config_slv_error to 0 from the next cycle.
REQ-025 SHALL NOT clear table contents on reset; writes in a reset cycle are discarded.
REQ-026 SHALL discard a schedule or config read issued in the cycle reset is asserted (no response after release).

Structure
REQ-027 SHALL place entry field bit-ranges, the 32-bit entry width and the 8-bit index width in the shared NoC package, used also by the TDM controller.
REQ-028 SHALL instantiate one sub-module, stbl_ram: synchronous read, read-before-write dual-port RAM, STBL_DEPTH x 32, not reset.

Verification
REQ-029 SHALL check: write idx 5 = 0x1234_3B07 (t2n=3, pkt_len=5, dma_valid=1, dma_num=7), then stbl_idx=5 with stbl_idx_en, run=1 -> next cycle route=0x1234, t2n=3, pkt_len=5, dma_num=7, dma_en=1 for one cycle.
REQ-030 SHALL check: same entry with run=0 -> fields updated, dma_en=0.
REQ-031 SHALL check: write config_addr=0x0100 -> config_slv_error=1 next cycle, rdata=0, table unchanged on read-back of idx 0.
REQ-032 SHALL check: same-cycle config write idx 9 = 0xAAAA_1000 and stbl_idx=9 -> schedule output shows old entry; next stbl_idx_en on 9 shows 0xAAAA, t2n=1.
REQ-033 SHALL check: reset pulse mid-schedule -> all outputs 0 next cycle; config read of previously written idx 5 after reset returns 0x1234_3B07.
REQ-034 SHALL check: STBL_DEPTH=16, stbl_idx=0x13 -> entry 3 output; config access to index 20 -> error.
